// File: rtl/fp_unpack_pkg.sv
// fp_unpack_pkg: raw-float record and widths shared by the recoded F32 unpack stage.
package fp_unpack_pkg;
    localparam int RECF32_W = 33;
    localparam int SEXP_W   = 10;
    localparam int SIG_W    = 25;

    typedef struct packed {
        logic              invalidExc;
        logic              isNaN;
        logic              isInf;
        logic              isZero;
        logic              sign;
        logic [SEXP_W-1:0] sExp;
        logic [SIG_W-1:0]  sig;
    } raw_rec_t;
endpackage

// File: rtl/recf32_raw_unpack.sv
// recf32_raw_unpack: combinational split of a recoded F32 operand into raw-float fields.
module recf32_raw_unpack
    import fp_unpack_pkg::*;
(
    input  logic [RECF32_W-1:0] i_bits,
    output raw_rec_t            o_raw
);
    logic [8:0]  w_exp;
    logic [22:0] w_fract;
    logic        w_is_zero;
    logic        w_is_nan;

    assign w_exp     = i_bits[31:23];
    assign w_fract   = i_bits[22:0];
    assign w_is_zero = w_exp[8:6] == 3'b000;
    assign w_is_nan  = w_exp[8:6] == 3'b111;

    // A NaN with the quiet bit clear is signaling and raises invalid.
    assign o_raw.invalidExc = w_is_nan & ~w_fract[22];
    assign o_raw.isNaN      = w_is_nan;
    assign o_raw.isInf      = w_exp[8:6] == 3'b110;
    assign o_raw.isZero     = w_is_zero;
    assign o_raw.sign       = i_bits[32];
    assign o_raw.sExp       = {1'b0, w_exp};
    assign o_raw.sig        = {1'b0, ~w_is_zero, w_fract};
endmodule

// File: rtl/recf32_unpack_stage.sv
// recf32_unpack_stage: unpacks recoded F32 operands and buffers raw records in a DEPTH-entry FIFO.
// Optional RECF32_UNPACK_SNAN_COUNT_EN adds a saturating signaling-NaN push counter.
module recf32_unpack_stage
    import fp_unpack_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                io_in_valid,
    output logic                io_in_ready,
    input  logic [RECF32_W-1:0] io_in_bits,
    output logic                io_out_valid,
    input  logic                io_out_ready,
    output logic                io_invalidExc,
    output logic                io_in_isNaN,
    output logic                io_in_isInf,
    output logic                io_in_isZero,
    output logic                io_in_sign,
    output logic [SEXP_W-1:0]   io_in_sExp,
    output logic [SIG_W-1:0]    io_in_sig
`ifdef RECF32_UNPACK_SNAN_COUNT_EN
    ,
    output logic [15:0]         io_snanCount
`endif
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    raw_rec_t        w_raw;
    raw_rec_t        w_head;
    raw_rec_t        r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            w_push;
    logic            w_pop;

    recf32_raw_unpack u_unpack (
        .i_bits (io_in_bits),
        .o_raw  (w_raw)
    );

    // Ready depends only on stored occupancy, so a full buffer blocks push even while popping.
    assign io_in_ready  = r_count < CW'(DEPTH);
    assign io_out_valid = r_count != '0;
    assign w_push       = io_in_valid & io_in_ready;
    assign w_pop        = io_out_valid & io_out_ready;
    assign w_head       = r_mem[r_rd_ptr];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_raw;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    assign io_invalidExc = w_head.invalidExc;
    assign io_in_isNaN   = w_head.isNaN;
    assign io_in_isInf   = w_head.isInf;
    assign io_in_isZero  = w_head.isZero;
    assign io_in_sign    = w_head.sign;
    assign io_in_sExp    = w_head.sExp;
    assign io_in_sig     = w_head.sig;

`ifdef RECF32_UNPACK_SNAN_COUNT_EN
    logic [15:0] r_snan_cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_snan_cnt <= '0;
        else if (w_push && w_raw.invalidExc && r_snan_cnt != 16'hFFFF) r_snan_cnt <= r_snan_cnt + 16'd1;
    end

    assign io_snanCount = r_snan_cnt;
`endif
endmodule

// File: tb/tb_recf32_unpack_stage.sv
// tb_recf32_unpack_stage: directed self-checking bench for recf32_unpack_stage (DEPTH=2).
// Checks io_snanCount too when RECF32_UNPACK_SNAN_COUNT_EN is defined.
module tb_recf32_unpack_stage;
    logic        clock = 1'b0;
    logic        reset_n;
    logic        io_in_valid;
    logic        io_in_ready;
    logic [32:0] io_in_bits;
    logic        io_out_valid;
    logic        io_out_ready;
    logic        io_invalidExc;
    logic        io_in_isNaN;
    logic        io_in_isInf;
    logic        io_in_isZero;
    logic        io_in_sign;
    logic [9:0]  io_in_sExp;
    logic [24:0] io_in_sig;
`ifdef RECF32_UNPACK_SNAN_COUNT_EN
    logic [15:0] io_snanCount;
`endif

    int errors = 0;
    int checks = 0;

    recf32_unpack_stage #(.DEPTH(2)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .io_in_valid   (io_in_valid),
        .io_in_ready   (io_in_ready),
        .io_in_bits    (io_in_bits),
        .io_out_valid  (io_out_valid),
        .io_out_ready  (io_out_ready),
        .io_invalidExc (io_invalidExc),
        .io_in_isNaN   (io_in_isNaN),
        .io_in_isInf   (io_in_isInf),
        .io_in_isZero  (io_in_isZero),
        .io_in_sign    (io_in_sign),
        .io_in_sExp    (io_in_sExp),
        .io_in_sig     (io_in_sig)
`ifdef RECF32_UNPACK_SNAN_COUNT_EN
        ,
        .io_snanCount  (io_snanCount)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Head record packed as {invalidExc,isNaN,isInf,isZero,sign,sExp,sig}.
    function automatic logic [39:0] head();
        return {io_invalidExc, io_in_isNaN, io_in_isInf, io_in_isZero, io_in_sign, io_in_sExp, io_in_sig};
    endfunction

    function automatic logic [39:0] rec(input logic inv, input logic nan, input logic inf, input logic zero,
                                        input logic sgn, input logic [9:0] sexp, input logic [24:0] sig);
        return {inv, nan, inf, zero, sgn, sexp, sig};
    endfunction

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        reset_n      = 1'b0;
        io_in_valid  = 1'b0;
        io_in_bits   = '0;
        io_out_ready = 1'b1;
        #12;
        chk("rst_out_valid", 40'(io_out_valid), 40'd0);
        chk("rst_in_ready", 40'(io_in_ready), 40'd1);
        chk("rst_head", head(), 40'd0);
        @(negedge clock);
        reset_n = 1'b1;
        step();

        // +1.0, one-cycle latency
        io_in_valid = 1'b1; io_in_bits = 33'h0_8000_0000;
        step();
        io_in_valid = 1'b0;
        chk("one_valid", 40'(io_out_valid), 40'd1);
        chk("one_head", head(), rec(0, 0, 0, 0, 0, 10'h100, 25'h0800000));
        step();
        chk("one_drained", 40'(io_out_valid), 40'd0);

        // back-to-back -1.0 then zero, with simultaneous push/pop
        io_in_valid = 1'b1; io_in_bits = 33'h1_8000_0000;
        step();
        io_in_bits = 33'h0_0000_0000;
        chk("b2b_first", head(), rec(0, 0, 0, 0, 1, 10'h100, 25'h0800000));
        step();
        io_in_valid = 1'b0;
        chk("b2b_second_valid", 40'(io_out_valid), 40'd1);
        chk("b2b_second", head(), rec(0, 0, 0, 1, 0, 10'h000, 25'h0000000));
        step();
        chk("b2b_drained", 40'(io_out_valid), 40'd0);

        // signaling NaN
        io_in_valid = 1'b1; io_in_bits = 33'h0_E000_0001;
        step();
        io_in_valid = 1'b0;
        chk("snan", head(), rec(1, 1, 0, 0, 0, 10'h1C0, 25'h0800001));
        step();
        // quiet NaN
        io_in_valid = 1'b1; io_in_bits = 33'h0_E040_0000;
        step();
        io_in_valid = 1'b0;
        chk("qnan", head(), rec(0, 1, 0, 0, 0, 10'h1C0, 25'h0C00000));
`ifdef RECF32_UNPACK_SNAN_COUNT_EN
        chk("snan_count", 40'(io_snanCount), 40'd1);
`endif
        step();

        // infinity
        io_in_valid = 1'b1; io_in_bits = 33'h0_C000_0000;
        step();
        io_in_valid = 1'b0;
        chk("inf", head(), rec(0, 0, 1, 0, 0, 10'h180, 25'h0800000));
        step();
        chk("inf_drained", 40'(io_out_valid), 40'd0);

        // fill with out_ready low
        io_out_ready = 1'b0;
        io_in_valid = 1'b1; io_in_bits = 33'h0_4000_0000;
        step();
        chk("fill1_ready", 40'(io_in_ready), 40'd1);
        io_in_bits = 33'h1_C000_0000;
        step();
        chk("full_ready", 40'(io_in_ready), 40'd0);
        chk("full_head", head(), rec(0, 0, 0, 0, 0, 10'h080, 25'h0800000));
        io_in_bits = 33'h0_0000_0000;
        step();
        chk("full_stable", head(), rec(0, 0, 0, 0, 0, 10'h080, 25'h0800000));
        chk("full_still_blocked", 40'(io_in_ready), 40'd0);
        // pop while push attempted: push must stay blocked this cycle
        io_out_ready = 1'b1;
        #1;
        chk("no_comb_ready", 40'(io_in_ready), 40'd0);
        step();
        io_in_valid = 1'b0;
        chk("pop1_ready", 40'(io_in_ready), 40'd1);
        chk("pop1_head", head(), rec(0, 0, 1, 0, 1, 10'h180, 25'h0800000));
        step();
        chk("pop2_empty", 40'(io_out_valid), 40'd0);

        // reset mid-operation
        io_out_ready = 1'b0;
        io_in_valid = 1'b1; io_in_bits = 33'h0_8000_0000;
        step();
        io_in_valid = 1'b0;
        chk("prerst_valid", 40'(io_out_valid), 40'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_valid", 40'(io_out_valid), 40'd0);
        chk("midrst_ready", 40'(io_in_ready), 40'd1);
        chk("midrst_head", head(), 40'd0);
        @(negedge clock);
        reset_n = 1'b1;
        io_out_ready = 1'b1;
        step();
        step();
        chk("postrst_empty", 40'(io_out_valid), 40'd0);
`ifdef RECF32_UNPACK_SNAN_COUNT_EN
        chk("postrst_snan_count", 40'(io_snanCount), 40'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
